// File: rtl/led_meter_pkg.sv
// Shared types and widths for the LED level-meter datapath.
// Imported by the magnitude front end and the level sequencer.
package led_meter_pkg;

  localparam int SAMPLE_W = 12;
  localparam int LEVEL_W  = 6;
  localparam int MAG_W    = 11;

  localparam logic [SAMPLE_W-1:0] MID_SCALE = 12'd2048;

  typedef enum logic {
    HOLD  = 1'b0,
    DECAY = 1'b1
  } meter_state_t;

  // Coarse display level is the top LEVEL_W bits of the magnitude.
  function automatic logic [LEVEL_W-1:0] mag_to_level(input logic [MAG_W-1:0] mag);
    return mag[MAG_W-1 -: LEVEL_W];
  endfunction

endpackage

// File: rtl/adc_magnitude.sv
// Offset-binary ADC sample to unsigned magnitude, plus rail (clip) detection.
// Purely combinational so it can be shared by further meter channels.
module adc_magnitude
  import led_meter_pkg::*;
(
  input  logic [SAMPLE_W-1:0] sample,
  output logic [MAG_W-1:0]    mag,
  output logic                clip
);

  // The MSB selects the half around MID_SCALE: sample-2048 is the low bits,
  // 2047-sample is their complement.
  always_comb begin
    if (sample >= MID_SCALE) begin
      mag = sample[MAG_W-1:0];
    end else begin
      mag = ~sample[MAG_W-1:0];
    end
  end

  assign clip = (sample == '0) || (sample == '1);

endmodule

// File: rtl/led_level_sched.sv
// Windowed peak meter with peak-hold / decay ballistics for the LED bar graph.
// One level, update strobe and clip flag are published per WIN_LEN valid samples.
module led_level_sched
  import led_meter_pkg::*;
#(
  parameter int WIN_LEN      = 512,
  parameter int WIN_W        = 9,
  parameter int HOLD_WINDOWS = 8,
  parameter int DECAY_STEP   = 1
) (
  input  logic        dclk,
  input  logic        rst,
  input  logic        sample_valid,
  input  logic [11:0] sample,
  output logic [5:0]  level,
  output logic        level_update,
  output logic        clip
);

  localparam int HC_W = $clog2(HOLD_WINDOWS + 1);
  localparam logic [WIN_W-1:0]   WIN_LAST = WIN_W'(WIN_LEN - 1);
  localparam logic [HC_W-1:0]    HOLD_MAX = HC_W'(HOLD_WINDOWS);
  localparam logic [LEVEL_W-1:0] STEP     = LEVEL_W'(DECAY_STEP);

  logic [MAG_W-1:0]   mag;
  logic               sample_clip;
  logic [LEVEL_W-1:0] cand;
  logic [LEVEL_W-1:0] win_peak;
  logic               win_clip;
  logic               win_close;

  logic [WIN_W-1:0]   win_cnt_reg;
  logic [LEVEL_W-1:0] peak_acc_reg;
  logic               clip_acc_reg;
  logic               clip_reg;
  logic               level_update_reg;

  meter_state_t       state_reg, state_next;
  logic [HC_W-1:0]    hold_cnt_reg, hold_cnt_next;
  logic [LEVEL_W-1:0] level_reg, level_next;
  logic [LEVEL_W-1:0] level_dec;

  adc_magnitude u_mag (
    .sample (sample),
    .mag    (mag),
    .clip   (sample_clip)
  );

  assign cand      = mag_to_level(mag);
  assign win_close = sample_valid && (win_cnt_reg == WIN_LAST);
  // Closing sample joins the window through these combinational terms.
  assign win_peak  = (cand > peak_acc_reg) ? cand : peak_acc_reg;
  assign win_clip  = clip_acc_reg | sample_clip;

  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      win_cnt_reg      <= '0;
      peak_acc_reg     <= '0;
      clip_acc_reg     <= 1'b0;
      clip_reg         <= 1'b0;
      level_update_reg <= 1'b0;
    end else begin
      level_update_reg <= win_close;
      if (win_close) begin
        win_cnt_reg  <= '0;
        peak_acc_reg <= '0;
        clip_acc_reg <= 1'b0;
        clip_reg     <= win_clip;
      end else if (sample_valid) begin
        win_cnt_reg  <= win_cnt_reg + 1'b1;
        peak_acc_reg <= win_peak;
        clip_acc_reg <= win_clip;
      end
    end
  end

  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      state_reg    <= HOLD;
      hold_cnt_reg <= '0;
      level_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
      level_reg    <= level_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    if (win_close) begin
      if (win_peak >= level_reg) begin
        state_next    = HOLD;
        hold_cnt_next = '0;
      end else if (state_reg == HOLD) begin
        hold_cnt_next = (hold_cnt_reg == HOLD_MAX) ? hold_cnt_reg : hold_cnt_reg + 1'b1;
        if (hold_cnt_next == HOLD_MAX) begin
          state_next = DECAY;
        end
      end
    end
  end

  // Decay never falls below the current window's peak and never wraps below 0.
  assign level_dec = (level_reg > STEP) ? (level_reg - STEP) : '0;

  always_comb begin
    level_next = level_reg;
    if (win_close) begin
      if (win_peak >= level_reg) begin
        level_next = win_peak;
      end else if (state_reg == DECAY) begin
        level_next = (level_dec > win_peak) ? level_dec : win_peak;
      end
    end
  end

  assign level        = level_reg;
  assign level_update = level_update_reg;
  assign clip         = clip_reg;

endmodule
